// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-state memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int unsigned DEFAULT_WAIT_CYCLES = 2;
    // Wide enough for the largest allowed wait count (15).
    localparam int unsigned CNT_WIDTH           = 4;

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, registered synchronous read.
// Only the read register is reset; the storage itself is not.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] storage [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            storage[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= storage[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: valid/ready handshake with optional wait states before ready.
// Define MEM_WAIT_STATE_EN to enable WAIT_CYCLES wait states; otherwise ready follows acceptance.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH       = `WIDTH,
    parameter int unsigned ADDR_WIDTH  = `ADDR_WIDTH,
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_rd,
    input  logic                  valid,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  ready
);

`ifdef MEM_WAIT_STATE_EN
    localparam int unsigned EFF_WAIT = WAIT_CYCLES;
`else
    // Without wait-state support the configured count has no effect.
    localparam int unsigned EFF_WAIT = 0 * WAIT_CYCLES;
`endif

    state_t                state;
    logic                  accept;
    logic                  direct;
    logic                  mem_we;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata;

    assign accept = (state == IDLE) && valid;
    // Zero-wait transfers hit storage on the accepting edge, straight from the inputs.
    assign direct = accept && (EFF_WAIT == 0);

`ifdef MEM_WAIT_STATE_EN
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WIDTH-1:0]      wdata_q;
    logic                  wait_done;

    assign wait_done = (state == WAIT) && (cnt == CNT_WIDTH'(1));
    assign mem_we    = (direct && wr_rd)  || (wait_done && wr_q);
    assign mem_re    = (direct && !wr_rd) || (wait_done && !wr_q);
    assign mem_addr  = direct ? addr  : addr_q;
    assign mem_wdata = direct ? wdata : wdata_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= wr_rd;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end
`else
    assign mem_we    = direct && wr_rd;
    assign mem_re    = direct && !wr_rd;
    assign mem_addr  = addr;
    assign mem_wdata = wdata;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ready <= 1'b0;
`ifdef MEM_WAIT_STATE_EN
            cnt   <= '0;
`endif
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
`ifdef MEM_WAIT_STATE_EN
                        cnt <= CNT_WIDTH'(EFF_WAIT);
                        if (EFF_WAIT != 0) begin
                            state <= WAIT;
                        end else begin
                            state <= RESP;
                            ready <= 1'b1;
                        end
`else
                        state <= RESP;
                        ready <= 1'b1;
`endif
                    end
                end
`ifdef MEM_WAIT_STATE_EN
                WAIT: begin
                    cnt <= cnt - CNT_WIDTH'(1);
                    if (cnt == CNT_WIDTH'(1)) begin
                        state <= RESP;
                        ready <= 1'b1;
                    end
                end
`endif
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    mem_array #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder; expectations follow MEM_WAIT_STATE_EN (W=3) or zero wait.
module tb_mem_responder;

`ifdef MEM_WAIT_STATE_EN
    localparam int          W          = 3;
    localparam logic [31:0] EXP_RST_RD = 32'h0000_00AA;
    localparam int          EXP_PULSES = 0;
`else
    localparam int          W          = 0;
    localparam logic [31:0] EXP_RST_RD = 32'h0000_0055;
    localparam int          EXP_PULSES = 1;
`endif

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        wr_rd = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    mem_responder #(
        .WIDTH       (32),
        .ADDR_WIDTH  (8),
        .WAIT_CYCLES (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_rd (wr_rd),
        .valid (valid),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ready (ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Drives one transfer and measures ready latency (edges after acceptance), pulse width,
    // cycle of the ready rise and the rdata seen with ready. Returns #1 after the edge that
    // ends the pulse, so a caller holding valid gets the next acceptance on the following edge.
    task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                        input bit drop, input bit keep,
                        output int lat, output int width, output int rise,
                        output logic [31:0] rd);
        wr_rd = w;
        addr  = a;
        wdata = d;
        valid = 1'b1;
        lat   = -1;
        width = 0;
        rise  = -1;
        rd    = 'x;
        @(posedge clk);
        #1;
        for (int i = 0; i < 40; i++) begin
            if (drop) valid = 1'b0;
            if (ready === 1'b1) begin
                if (lat < 0) begin
                    lat  = i;
                    rise = cyc;
                    rd   = rdata;
                end
                width++;
            end else if (lat >= 0) begin
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!keep) valid = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        #1;
        total++;
        if (ready !== 1'b0) $display("FAIL reset_ready: got %b, expected 0", ready);
        else passed++;
        total++;
        if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h, expected 0", rdata);
        else passed++;
        valid = 1'b1;
        wr_rd = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (ready !== 1'b0) $display("FAIL reset_hold_ready: got %b, expected 0", ready);
        else passed++;
        valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_basic();
        int lat, wid, rise;
        logic [31:0] rd;
        xfer(1'b1, 8'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, lat, wid, rise, rd);
        total++;
        if (lat !== W) $display("FAIL basic_wr_latency: got %0d, expected %0d", lat, W);
        else passed++;
        total++;
        if (wid !== 1) $display("FAIL basic_wr_width: got %0d, expected 1", wid);
        else passed++;
        xfer(1'b0, 8'h10, 32'h0, 1'b0, 1'b0, lat, wid, rise, rd);
        total++;
        if (lat !== W) $display("FAIL basic_rd_latency: got %0d, expected %0d", lat, W);
        else passed++;
        total++;
        if (wid !== 1) $display("FAIL basic_rd_width: got %0d, expected 1", wid);
        else passed++;
        total++;
        if (rd !== 32'hDEAD_BEEF) $display("FAIL basic_rd_data: got %h, expected deadbeef", rd);
        else passed++;
        total++;
        if (rdata !== 32'hDEAD_BEEF) $display("FAIL rdata_hold: got %h, expected deadbeef", rdata);
        else passed++;
        xfer(1'b1, 8'h11, 32'hCAFE_F00D, 1'b0, 1'b0, lat, wid, rise, rd);
        total++;
        if (rdata !== 32'hDEAD_BEEF)
            $display("FAIL rdata_during_write: got %h, expected deadbeef", rdata);
        else passed++;
    endtask

    task automatic test_wait_read();
        int lat, wid, rise;
        logic [31:0] rd;
        xfer(1'b0, 8'h11, 32'h0, 1'b0, 1'b0, lat, wid, rise, rd);
        total++;
        if (lat !== W) $display("FAIL wait_latency: got %0d, expected %0d", lat, W);
        else passed++;
        total++;
        if (wid !== 1) $display("FAIL wait_width: got %0d, expected 1", wid);
        else passed++;
        total++;
        if (rd !== 32'hCAFE_F00D) $display("FAIL wait_rd_data: got %h, expected cafef00d", rd);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int lat, wid;
        int rise [4];
        logic [31:0] rd0, rd1, rd2, rd3;
        xfer(1'b1, 8'h00, 32'h1, 1'b0, 1'b1, lat, wid, rise[0], rd0);
        xfer(1'b1, 8'hFF, 32'h2, 1'b0, 1'b1, lat, wid, rise[1], rd1);
        xfer(1'b0, 8'h00, 32'h0, 1'b0, 1'b1, lat, wid, rise[2], rd2);
        xfer(1'b0, 8'hFF, 32'h0, 1'b0, 1'b0, lat, wid, rise[3], rd3);
        for (int i = 1; i < 4; i++) begin
            total++;
            if (rise[i] - rise[i-1] !== W + 2)
                $display("FAIL b2b_spacing_%0d: got %0d, expected %0d", i,
                         rise[i] - rise[i-1], W + 2);
            else passed++;
        end
        total++;
        if (rd2 !== 32'h1) $display("FAIL b2b_rd_00: got %h, expected 00000001", rd2);
        else passed++;
        total++;
        if (rd3 !== 32'h2) $display("FAIL b2b_rd_ff: got %h, expected 00000002", rd3);
        else passed++;
    endtask

    task automatic test_wrap();
        int lat, wid, rise;
        logic [31:0] rd;
        xfer(1'b1, 8'hFF, 32'h1234, 1'b0, 1'b0, lat, wid, rise, rd);
        xfer(1'b1, 8'h00, 32'h5678, 1'b0, 1'b0, lat, wid, rise, rd);
        xfer(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, lat, wid, rise, rd);
        total++;
        if (rd !== 32'h5678) $display("FAIL wrap_rd_00: got %h, expected 00005678", rd);
        else passed++;
        xfer(1'b0, 8'hFF, 32'h0, 1'b0, 1'b0, lat, wid, rise, rd);
        total++;
        if (rd !== 32'h1234) $display("FAIL wrap_rd_ff: got %h, expected 00001234", rd);
        else passed++;
    endtask

    task automatic test_reset_mid_wait();
        int lat, wid, rise, npulse;
        logic [31:0] rd;
        xfer(1'b1, 8'h20, 32'hAA, 1'b0, 1'b0, lat, wid, rise, rd);
        npulse = 0;
        wr_rd = 1'b1;
        addr  = 8'h20;
        wdata = 32'h55;
        valid = 1'b1;
        @(posedge clk);
        #1;
        if (ready === 1'b1) npulse++;
        valid = 1'b0;
        @(posedge clk);
        #1;
        if (ready === 1'b1) npulse++;
        rst = 1'b0;
        #1;
        total++;
        if (ready !== 1'b0) $display("FAIL midrst_ready: got %b, expected 0", ready);
        else passed++;
        total++;
        if (rdata !== 32'h0) $display("FAIL midrst_rdata: got %h, expected 0", rdata);
        else passed++;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) npulse++;
        end
        rst = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) npulse++;
        end
        total++;
        if (npulse !== EXP_PULSES)
            $display("FAIL midrst_pulses: got %0d, expected %0d", npulse, EXP_PULSES);
        else passed++;
        xfer(1'b0, 8'h20, 32'h0, 1'b0, 1'b0, lat, wid, rise, rd);
        total++;
        if (lat !== W) $display("FAIL midrst_rd_latency: got %0d, expected %0d", lat, W);
        else passed++;
        total++;
        if (rd !== EXP_RST_RD) $display("FAIL midrst_rd_data: got %h, expected %h", rd, EXP_RST_RD);
        else passed++;
    endtask

    task automatic test_early_drop();
        int lat, wid, rise;
        logic [31:0] rd;
        xfer(1'b1, 8'h03, 32'h77, 1'b1, 1'b0, lat, wid, rise, rd);
        total++;
        if (lat !== W) $display("FAIL drop_latency: got %0d, expected %0d", lat, W);
        else passed++;
        total++;
        if (wid !== 1) $display("FAIL drop_width: got %0d, expected 1", wid);
        else passed++;
        xfer(1'b0, 8'h03, 32'h0, 1'b0, 1'b0, lat, wid, rise, rd);
        total++;
        if (rd !== 32'h77) $display("FAIL drop_rd_data: got %h, expected 00000077", rd);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_read();
        test_back_to_back();
        test_wrap();
        test_reset_mid_wait();
        test_early_drop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
